// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master io bus arbiter.
// State encoding is fixed so debug tooling can decode dbg_state directly.
package io_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int unsigned IO_ARB_TIMEOUT  = 1023;
  localparam logic [31:0] IO_ARB_ERR_DATA = 32'hDEAD_BEEF;

  // Owner index (0 = m0, 1 = m1) to one-hot grant vector.
  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Per-master request/response bundle between one bus master and the arbiter.
// One instance per master; the arbiter takes the slave modport.
interface io_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: a request (read or write high, write wins if both) is held
  // with stable addr/wdata until ready pulses for one cycle; read_ready
  // marks each read beat, and rdata is only meaningful on read_ready/ready.
  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic              burst;
  logic [2:0]        burst_size;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        byte_size;
  logic [DATA_W-1:0] rdata;
  logic              read_ready;
  logic              ready;

  modport master (
    output addr, read, write, burst, burst_size, wdata, byte_size,
    input  rdata, read_ready, ready
  );

  modport slave (
    input  addr, read, write, burst, burst_size, wdata, byte_size,
    output rdata, read_ready, ready
  );

endinterface

// File: rtl/io_arb_rr2.sv
// Combinational two-way round-robin pick: a sole requester always wins,
// on contention the master that did not own the bus last time wins.
module io_arb_rr2
  import io_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = owner_onehot(~last_grant);
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter in front of the peripheral io bus: latches the
// granted request, forwards beats/completion to the owner, and times out hung transfers.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int unsigned       TIMEOUT  = IO_ARB_TIMEOUT,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(IO_ARB_ERR_DATA)
) (
  input  logic               clk,
  input  logic               rst_n,
  io_bus_arbiter_if.slave    m0,
  io_bus_arbiter_if.slave    m1,
  output logic [ADDR_W-1:0]  io_addr,
  output logic [DATA_W-1:0]  io_wdata,
  output logic               io_read,
  output logic               io_write,
  output logic               burst,
  output logic [2:0]         burst_size,
  output logic [1:0]         io_byte_size,
  input  logic [DATA_W-1:0]  io_rdata,
  input  logic               read_ready,
  input  logic               io_ready,
  output logic [1:0]         grant,
  output logic               bus_timeout,
  output arb_state_t         dbg_state
);

  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  arb_state_t state_q, state_d;

  logic [1:0]        req, pick;
  logic              last_grant_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [DATA_W-1:0] wdata_q, sel_wdata;
  logic [1:0]        byte_q, sel_byte;
  logic [2:0]        bsize_q, sel_bsize;
  logic              wr_q, sel_wr;
  logic              burst_q, sel_burst;
  logic [CW-1:0]     cnt_q;
  logic              done_ok, done_to;

  assign req = {m1.read | m1.write, m0.read | m0.write};

  io_arb_rr2 u_rr2 (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (pick)
  );

  // Write wins over read; a burst is only honoured for reads.
  always_comb begin
    if (pick[1]) begin
      sel_addr  = m1.addr;
      sel_wdata = m1.wdata;
      sel_byte  = m1.byte_size;
      sel_bsize = m1.burst_size;
      sel_wr    = m1.write;
      sel_burst = m1.burst & ~m1.write;
    end else begin
      sel_addr  = m0.addr;
      sel_wdata = m0.wdata;
      sel_byte  = m0.byte_size;
      sel_bsize = m0.burst_size;
      sel_wr    = m0.write;
      sel_burst = m0.burst & ~m0.write;
    end
  end

  // io_ready beats a coincident timeout, so done_to requires !io_ready.
  assign done_ok = (state_q == BUSY) && io_ready;
  assign done_to = (TIMEOUT != 0) && (state_q == BUSY) && !io_ready && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = BUSY;
      BUSY:    if (done_ok || done_to) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      byte_q       <= '0;
      bsize_q      <= '0;
      wr_q         <= 1'b0;
      burst_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (state_q == IDLE && (|pick)) begin
        owner_q <= pick[1];
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        byte_q  <= sel_byte;
        bsize_q <= sel_bsize;
        wr_q    <= sel_wr;
        burst_q <= sel_burst;
      end
      if (state_q == RELEASE) last_grant_q <= owner_q;
      if (state_q != BUSY) cnt_q <= '0;
      else if (cnt_q != '1) cnt_q <= cnt_q + CW'(1);
    end
  end

  always_comb begin
    io_addr       = '0;
    io_wdata      = '0;
    io_read       = 1'b0;
    io_write      = 1'b0;
    burst         = 1'b0;
    burst_size    = '0;
    io_byte_size  = '0;
    grant         = 2'b00;
    bus_timeout   = 1'b0;
    m0.rdata      = '0;
    m0.read_ready = 1'b0;
    m0.ready      = 1'b0;
    m1.rdata      = '0;
    m1.read_ready = 1'b0;
    m1.ready      = 1'b0;
    if (state_q == BUSY) begin
      io_addr      = addr_q;
      io_wdata     = wdata_q;
      io_read      = ~wr_q;
      io_write     = wr_q;
      burst        = burst_q;
      burst_size   = bsize_q;
      io_byte_size = byte_q;
      grant        = owner_onehot(owner_q);
      bus_timeout  = done_to;
      if (!owner_q) begin
        m0.rdata      = done_to ? ERR_DATA : io_rdata;
        m0.read_ready = read_ready;
        m0.ready      = done_ok | done_to;
      end else begin
        m1.rdata      = done_to ? ERR_DATA : io_rdata;
        m1.read_ready = read_ready;
        m1.ready      = done_ok | done_to;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: scenario tasks with inline checks plus a
// scoreboard of expected {master, rdata} completions popped on every read_ready/ready.
module tb_io_bus_arbiter;
  import io_bus_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic        io_read, io_write, burst, read_ready, io_ready, bus_timeout;
  logic [2:0]  burst_size;
  logic [1:0]  io_byte_size, grant;
  arb_state_t  dbg_state;

  logic [32:0] exp_q[$];
  logic [32:0] sb_exp;
  int vectors = 0;
  int miscompares = 0;

  io_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
  io_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();

  io_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_bus), .m1(m1_bus),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_read(io_read), .io_write(io_write),
    .burst(burst), .burst_size(burst_size), .io_byte_size(io_byte_size),
    .io_rdata(io_rdata), .read_ready(read_ready), .io_ready(io_ready),
    .grant(grant), .bus_timeout(bus_timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // scoreboard: every owner strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (m0_bus.read_ready || m0_bus.ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_m0 unexpected strobe rdata=%h", m0_bus.rdata);
        end else begin
          sb_exp = exp_q.pop_front();
          if ({1'b0, m0_bus.rdata} !== sb_exp) begin
            miscompares++;
            $display("FAIL sb_m0 got m0/%h expected m%0d/%h", m0_bus.rdata, sb_exp[32], sb_exp[31:0]);
          end
        end
      end
      if (m1_bus.read_ready || m1_bus.ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_m1 unexpected strobe rdata=%h", m1_bus.rdata);
        end else begin
          sb_exp = exp_q.pop_front();
          if ({1'b1, m1_bus.rdata} !== sb_exp) begin
            miscompares++;
            $display("FAIL sb_m1 got m1/%h expected m%0d/%h", m1_bus.rdata, sb_exp[32], sb_exp[31:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_bus.addr = '0; m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.burst = 1'b0;
    m0_bus.burst_size = '0; m0_bus.wdata = '0; m0_bus.byte_size = '0;
    m1_bus.addr = '0; m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.burst = 1'b0;
    m1_bus.burst_size = '0; m1_bus.wdata = '0; m1_bus.byte_size = '0;
    io_rdata = '0; read_ready = 1'b0; io_ready = 1'b0;
  endtask

  // Slave answers with io_ready in the lat-th cycle from now; the served master then drops its request.
  task automatic serve(input logic mid, input int lat, input logic [31:0] data);
    for (int i = 1; i <= lat; i++) begin
      if (i == lat) begin
        io_ready = 1'b1;
        io_rdata = data;
        exp_q.push_back({mid, data});
      end
      cyc();
    end
    io_ready = 1'b0;
    io_rdata = '0;
    if (mid) begin m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.burst = 1'b0; end
    else     begin m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.burst = 1'b0; end
  endtask

  task automatic test_sb_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_sb_drained got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    vectors++;
    if ({grant, io_read, io_write, burst, bus_timeout, io_addr, dbg_state} !== {2'b00, 4'b0000, 32'h0, IDLE}) begin
      miscompares++;
      $display("FAIL reset_outputs got g=%b rd=%b wr=%b addr=%h st=%0d expected all 0/IDLE",
               grant, io_read, io_write, io_addr, dbg_state);
    end
    cyc();
    rst_n = 1'b1;
    read_ready = 1'b1;
    io_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({m0_bus.ready, m0_bus.read_ready, m1_bus.ready, m1_bus.read_ready, grant, dbg_state} !== {4'b0000, 2'b00, IDLE}) begin
      miscompares++;
      $display("FAIL idle_strobes_ignored got m0=%b%b m1=%b%b g=%b st=%0d expected 0",
               m0_bus.ready, m0_bus.read_ready, m1_bus.ready, m1_bus.read_ready, grant, dbg_state);
    end
    cyc();
    read_ready = 1'b0;
    io_ready = 1'b0;
  endtask

  // Both masters request every round: grants alternate starting with m0.
  task automatic test_contention();
    logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] e_addr;
    for (int r = 0; r < 4; r++) begin
      m0_bus.read = 1'b1;
      m0_bus.addr = 32'h0000_0100 + 32'(r);
      m1_bus.read = 1'b1;
      m1_bus.write = 1'b1;
      m1_bus.burst = 1'b1;
      m1_bus.burst_size = 3'd2;
      m1_bus.addr = 32'h0000_0200 + 32'(r);
      m1_bus.wdata = 32'hA000_0000 + 32'(r);
      @(negedge clk);
      vectors++;
      if (grant !== 2'b00) begin
        miscompares++;
        $display("FAIL cont_idle_grant r=%0d got %b expected 00", r, grant);
      end
      cyc();
      @(negedge clk);
      e_addr = exp_g[r][0] ? 32'h0000_0100 + 32'(r) : 32'h0000_0200 + 32'(r);
      vectors++;
      if ({grant, io_read, io_write, burst, io_addr} !== {exp_g[r], exp_g[r][0], exp_g[r][1], 1'b0, e_addr}) begin
        miscompares++;
        $display("FAIL cont_grant r=%0d got g=%b rd=%b wr=%b burst=%b addr=%h expected g=%b addr=%h",
                 r, grant, io_read, io_write, burst, io_addr, exp_g[r], e_addr);
      end
      if (exp_g[r][1]) begin
        vectors++;
        if (io_wdata !== 32'hA000_0000 + 32'(r)) begin
          miscompares++;
          $display("FAIL cont_wdata r=%0d got %h expected %h", r, io_wdata, 32'hA000_0000 + 32'(r));
        end
      end
      cyc();
      serve(exp_g[r][1], 1 + (r % 2), 32'hC0DE_0000 + 32'(r));
      @(negedge clk);
      vectors++;
      if ({grant, io_read, io_write, dbg_state} !== {2'b00, 2'b00, RELEASE}) begin
        miscompares++;
        $display("FAIL cont_release r=%0d got g=%b rd=%b wr=%b st=%0d expected 00/0/0/RELEASE",
                 r, grant, io_read, io_write, dbg_state);
      end
      cyc();
    end
    clear_inputs();
    test_sb_drained("contention");
  endtask

  task automatic test_single_read();
    m0_bus.addr = 32'h1000_0000;
    m0_bus.read = 1'b1;
    m0_bus.byte_size = 2'd2;
    @(negedge clk);
    vectors++;
    if ({grant, io_read} !== 3'b000) begin
      miscompares++;
      $display("FAIL single_latency got g=%b rd=%b expected 00/0", grant, io_read);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if ({grant, io_read, io_write, io_addr, io_byte_size, dbg_state} !== {2'b01, 2'b10, 32'h1000_0000, 2'd2, BUSY}) begin
      miscompares++;
      $display("FAIL single_busy got g=%b rd=%b wr=%b addr=%h bs=%0d st=%0d expected 01/1/0/10000000/2/BUSY",
               grant, io_read, io_write, io_addr, io_byte_size, dbg_state);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if ({io_read, m0_bus.ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_wait got rd=%b ready=%b expected 1/0", io_read, m0_bus.ready);
    end
    cyc();
    serve(1'b0, 2, 32'h1234_5678);
    @(negedge clk);
    vectors++;
    if ({grant, io_read, dbg_state} !== {2'b00, 1'b0, RELEASE}) begin
      miscompares++;
      $display("FAIL single_release got g=%b rd=%b st=%0d expected 00/0/RELEASE", grant, io_read, dbg_state);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if ({grant, dbg_state} !== {2'b00, IDLE}) begin
      miscompares++;
      $display("FAIL single_idle got g=%b st=%0d expected 00/IDLE", grant, dbg_state);
    end
    clear_inputs();
    test_sb_drained("single");
  endtask

  task automatic test_burst();
    logic [31:0] beats [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    m1_bus.addr = 32'h3000_0000;
    m1_bus.read = 1'b1;
    m1_bus.burst = 1'b1;
    m1_bus.burst_size = 3'd3;
    cyc();
    @(negedge clk);
    vectors++;
    if ({grant, io_read, burst, burst_size, io_addr} !== {2'b10, 1'b1, 1'b1, 3'd3, 32'h3000_0000}) begin
      miscompares++;
      $display("FAIL burst_start got g=%b rd=%b burst=%b bsz=%0d addr=%h expected 10/1/1/3/30000000",
               grant, io_read, burst, burst_size, io_addr);
    end
    for (int b = 0; b < 4; b++) begin
      cyc();
      read_ready = 1'b1;
      io_rdata = beats[b];
      exp_q.push_back({1'b1, beats[b]});
      @(negedge clk);
      vectors++;
      if ({m0_bus.rdata, m0_bus.read_ready, m0_bus.ready} !== 34'h0) begin
        miscompares++;
        $display("FAIL burst_m0_quiet beat=%0d got rdata=%h rr=%b rdy=%b expected 0",
                 b, m0_bus.rdata, m0_bus.read_ready, m0_bus.ready);
      end
    end
    cyc();
    read_ready = 1'b0;
    io_rdata = '0;
    serve(1'b1, 1, 32'h0000_0000);
    @(negedge clk);
    vectors++;
    if ({grant, io_read, burst, burst_size} !== 7'b0) begin
      miscompares++;
      $display("FAIL burst_release got g=%b rd=%b burst=%b bsz=%0d expected 0", grant, io_read, burst, burst_size);
    end
    cyc();
    clear_inputs();
    test_sb_drained("burst");
  endtask

  task automatic test_timeout();
    m0_bus.addr = 32'h4000_0000;
    m0_bus.read = 1'b1;
    cyc();
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) exp_q.push_back({1'b0, 32'hDEAD_BEEF});
      @(negedge clk);
      vectors++;
      if ({grant, io_read, bus_timeout} !== {2'b01, 1'b1, (c == 8)}) begin
        miscompares++;
        $display("FAIL timeout_cycle c=%0d got g=%b rd=%b to=%b expected 01/1/%0d",
                 c, grant, io_read, bus_timeout, (c == 8));
      end
      cyc();
    end
    m0_bus.read = 1'b0;
    @(negedge clk);
    vectors++;
    if ({grant, io_read, bus_timeout, dbg_state} !== {2'b00, 2'b00, RELEASE}) begin
      miscompares++;
      $display("FAIL timeout_release got g=%b rd=%b to=%b st=%0d expected 00/0/0/RELEASE",
               grant, io_read, bus_timeout, dbg_state);
    end
    cyc();
    clear_inputs();
    test_sb_drained("timeout");
  endtask

  task automatic test_addr_change();
    m0_bus.addr = 32'h1000_0000;
    m0_bus.read = 1'b1;
    cyc();
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) begin
        m0_bus.addr = 32'h2000_0000;
        m0_bus.read = 1'b0;
      end
      if (c == 3) begin
        io_ready = 1'b1;
        io_rdata = 32'h5A5A_0003;
        exp_q.push_back({1'b0, 32'h5A5A_0003});
      end
      @(negedge clk);
      vectors++;
      if ({grant, io_read, io_addr} !== {2'b01, 1'b1, 32'h1000_0000}) begin
        miscompares++;
        $display("FAIL addr_hold c=%0d got g=%b rd=%b addr=%h expected 01/1/10000000",
                 c, grant, io_read, io_addr);
      end
      cyc();
    end
    io_ready = 1'b0;
    io_rdata = '0;
    @(negedge clk);
    vectors++;
    if ({grant, io_read, io_addr} !== 35'h0) begin
      miscompares++;
      $display("FAIL addr_release got g=%b rd=%b addr=%h expected 0", grant, io_read, io_addr);
    end
    cyc();
    clear_inputs();
    test_sb_drained("addr_change");
  endtask

  task automatic test_reset_mid_busy();
    m0_bus.addr = 32'h1000_0000;
    m0_bus.read = 1'b1;
    cyc();
    @(negedge clk);
    vectors++;
    if (grant !== 2'b01) begin
      miscompares++;
      $display("FAIL rstbusy_grant got %b expected 01", grant);
    end
    cyc();
    rst_n = 1'b0;
    io_ready = 1'b1;
    read_ready = 1'b1;
    io_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    vectors++;
    if ({grant, io_read, io_write, io_addr, bus_timeout, m0_bus.ready, m0_bus.read_ready, m0_bus.rdata, dbg_state}
        !== {2'b00, 2'b00, 32'h0, 3'b000, 32'h0, IDLE}) begin
      miscompares++;
      $display("FAIL rstbusy_outputs got g=%b rd=%b addr=%h rdy=%b rdata=%h st=%0d expected 0/IDLE",
               grant, io_read, io_addr, m0_bus.ready, m0_bus.rdata, dbg_state);
    end
    cyc();
    clear_inputs();
    rst_n = 1'b1;
    cyc();
    m1_bus.addr = 32'h5000_0000;
    m1_bus.read = 1'b1;
    @(negedge clk);
    vectors++;
    if (grant !== 2'b00) begin
      miscompares++;
      $display("FAIL rstbusy_m1_req got %b expected 00", grant);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if ({grant, io_read, io_addr} !== {2'b10, 1'b1, 32'h5000_0000}) begin
      miscompares++;
      $display("FAIL rstbusy_m1_grant got g=%b rd=%b addr=%h expected 10/1/50000000", grant, io_read, io_addr);
    end
    cyc();
    serve(1'b1, 1, 32'h0000_0077);
    @(negedge clk);
    vectors++;
    if (grant !== 2'b00) begin
      miscompares++;
      $display("FAIL rstbusy_m1_release got %b expected 00", grant);
    end
    cyc();
    clear_inputs();
    test_sb_drained("reset_mid_busy");
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_burst();
    test_timeout();
    test_addr_change();
    test_reset_mid_busy();
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
